// File: rtl/banco_reg.sv
// Register bank for the 4-bit microcore: LDR / ULA write-back into R0 or Rd
// behind a three-state write handshake, plus two combinational read ports.
module banco_reg #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena_wr,
    input  logic              sel_r0_rd,
    input  logic              sel_ldr_ula,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] imm_data,
    input  logic [DATA_W-1:0] ula_res,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    output logic [DATA_W-1:0] r0_out,
    output logic              wr_ack,
    output logic [1:0]        bank_state
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              wr_ack_q;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DEPTH-1:0]  reg_we;
    logic [DATA_W-1:0] regs_q [DEPTH];

    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ena_wr) begin
                    wr_en   = 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_ACK:  state_d = ST_DONE;
            // Writes happen only in IDLE, so a lingering ena_wr here is harmless.
            ST_DONE: if (!ena_wr) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign wr_addr = sel_r0_rd   ? rd_addr  : '0;
    assign wr_data = sel_ldr_ula ? imm_data : ula_res;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_we
            assign reg_we[gi] = wr_en && (wr_addr == ADDR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            wr_ack_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ack_q <= (state_d == ST_ACK);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (reg_we[i]) regs_q[i] <= wr_data;
            end
        end
    end

    // No write-through: readers see the old value during the write cycle.
    assign ra_data    = regs_q[ra_addr];
    assign rb_data    = regs_q[rb_addr];
    assign r0_out     = regs_q[0];
    assign wr_ack     = wr_ack_q;
    assign bank_state = state_q;

endmodule
